// File: rtl/uart_rx_frame_ctrl.sv
// Receive frame controller: checks each SIPO frame and queues good bytes in a FWFT FIFO.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_frame_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic        baud_clk_rx,
    input  logic        rst,
    input  logic [10:0] parallel_data_rx,
    input  logic        received_flag,
    input  logic        active_flag_rx,
    input  logic        rd_en,
    input  logic        err_clr,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        fifo_full,
    output logic        frame_err,
    output logic        parity_err,
    output logic        overrun_err,
    output logic [7:0]  drop_cnt,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CHECK = 1'b1;

    logic [0:0]    state_reg;
    logic          flag_d_reg;
    logic [10:0]   frame_q_reg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg, count_next;
    logic          rd_valid_reg, fifo_full_reg;
    logic          frame_err_reg, overrun_err_reg;
    logic [7:0]    drop_cnt_reg;

    logic new_frame, in_check, framing_bad, parity_bad, no_room;
    logic set_frame_err, set_parity_err, set_overrun, push, pop, drop;

    assign new_frame   = received_flag & ~flag_d_reg;
    assign in_check    = (state_reg == ST_CHECK);
    assign framing_bad = frame_q_reg[0] | ~frame_q_reg[10];

`ifdef UART_RX_PARITY_EN
    logic parity_err_reg;
    assign parity_bad = ((^frame_q_reg[9:1]) != PARITY_ODD);
    assign parity_err = parity_err_reg;
`else
    logic unused_parity_bit;
    assign unused_parity_bit = frame_q_reg[9];
    assign parity_bad = 1'b0;
    assign parity_err = 1'b0;
`endif

    // A full FIFO can still accept the byte when the host pops in the same cycle.
    assign no_room        = fifo_full_reg & ~rd_en;
    assign set_frame_err  = in_check & framing_bad;
    assign set_parity_err = in_check & ~framing_bad & parity_bad;
    assign set_overrun    = in_check & ~framing_bad & ~parity_bad & no_room;
    assign push           = in_check & ~framing_bad & ~parity_bad & ~no_room;
    assign pop            = rd_en & rd_valid_reg;
    assign drop           = set_frame_err | set_parity_err | set_overrun;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge baud_clk_rx) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            flag_d_reg  <= 1'b1;
            frame_q_reg <= '0;
        end else begin
            flag_d_reg <= received_flag;
            case (state_reg)
                ST_IDLE: begin
                    if (new_frame) begin
                        frame_q_reg <= parallel_data_rx;
                        state_reg   <= ST_CHECK;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge baud_clk_rx) begin
        if (push) begin
            mem[wr_ptr_reg] <= frame_q_reg[8:1];
        end
    end

    always_ff @(posedge baud_clk_rx) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            rd_valid_reg  <= 1'b0;
            fifo_full_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            count_reg     <= count_next;
            rd_valid_reg  <= (count_next != '0);
            fifo_full_reg <= (count_next == FULL_CNT);
        end
    end

    // Error set beats a same-cycle clear, so a new drop after err_clr counts as 1.
    always_ff @(posedge baud_clk_rx) begin
        if (rst) begin
            frame_err_reg   <= 1'b0;
            overrun_err_reg <= 1'b0;
            drop_cnt_reg    <= '0;
        end else begin
            frame_err_reg   <= set_frame_err | (frame_err_reg & ~err_clr);
            overrun_err_reg <= set_overrun | (overrun_err_reg & ~err_clr);
            if (drop) begin
                if (err_clr)
                    drop_cnt_reg <= 8'd1;
                else if (drop_cnt_reg != 8'hFF)
                    drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end else if (err_clr) begin
                drop_cnt_reg <= '0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge baud_clk_rx) begin
        if (rst) parity_err_reg <= 1'b0;
        else     parity_err_reg <= set_parity_err | (parity_err_reg & ~err_clr);
    end
`endif

    assign rd_data     = rd_valid_reg ? mem[rd_ptr_reg] : 8'h00;
    assign rd_valid    = rd_valid_reg;
    assign fifo_full   = fifo_full_reg;
    assign frame_err   = frame_err_reg;
    assign overrun_err = overrun_err_reg;
    assign drop_cnt    = drop_cnt_reg;
    assign busy        = active_flag_rx | in_check;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized frame traffic.
module tb_uart_rx_frame_ctrl;

    localparam int DEPTH   = 4;
    localparam bit PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] pdata = '0;
    logic        rflag = 1'b0;
    logic        active = 1'b0;
    logic        rd_en = 1'b0;
    logic        err_clr = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid, fifo_full, frame_err, parity_err, overrun_err, busy;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(.FIFO_DEPTH(DEPTH), .PARITY_ODD(PAR_ODD)) dut (
        .baud_clk_rx      (clk),
        .rst              (rst),
        .parallel_data_rx (pdata),
        .received_flag    (rflag),
        .active_flag_rx   (active),
        .rd_en            (rd_en),
        .err_clr          (err_clr),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .fifo_full        (fifo_full),
        .frame_err        (frame_err),
        .parity_err       (parity_err),
        .overrun_err      (overrun_err),
        .drop_cnt         (drop_cnt),
        .busy             (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus error bookkeeping, advanced once per clock.
    logic [7:0]  mq[$];
    bit          m_ferr = 0, m_perr = 0, m_oerr = 0;
    int          m_drop = 0;
    bit          m_pending = 0;
    logic [10:0] m_frame = '0;
    bit          m_prev = 1;

    always @(posedge clk) begin : model
        int  sz0;
        bit  dropped;
        bit  nf;
        if (rst) begin
            mq.delete();
            m_ferr = 0; m_perr = 0; m_oerr = 0; m_drop = 0;
            m_pending = 0; m_prev = 1;
        end else begin
            sz0 = mq.size();
            nf = rflag && !m_prev && !m_pending;
            dropped = 0;
            if (err_clr) begin
                m_ferr = 0; m_perr = 0; m_oerr = 0; m_drop = 0;
            end
            if (rd_en && sz0 > 0) void'(mq.pop_front());
            if (m_pending) begin
                if (m_frame[0] != 1'b0 || m_frame[10] != 1'b1) begin
                    m_ferr = 1; dropped = 1;
                end else if (PAR_EN && ((^m_frame[9:1]) != PAR_ODD)) begin
                    m_perr = 1; dropped = 1;
                end else if (sz0 == DEPTH && !rd_en) begin
                    m_oerr = 1; dropped = 1;
                end else begin
                    mq.push_back(m_frame[8:1]);
                end
            end
            if (dropped) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            m_pending = nf;
            if (nf) m_frame = pdata;
            m_prev = rflag;
        end
    end

    always @(posedge clk) begin : compare
        #1;
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, mq.size() > 0});
        if (mq.size() > 0) chk("rd_data", {24'd0, rd_data}, {24'd0, mq[0]});
        chk("fifo_full", {31'd0, fifo_full}, {31'd0, mq.size() == DEPTH});
        chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
        chk("parity_err", {31'd0, parity_err}, {31'd0, m_perr});
        chk("overrun_err", {31'd0, overrun_err}, {31'd0, m_oerr});
        chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
        chk("busy", {31'd0, busy}, {31'd0, active | m_pending});
    end

    function automatic logic [10:0] mk(input logic [7:0] d, input bit good_par);
        logic p;
        p = (^d) ^ PAR_ODD;
        if (!good_par) p = ~p;
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns just after the edge that registers the check result; flag still high.
    task automatic send(input logic [10:0] f, input bit pop_in_check);
        pdata = f;
        rflag = 1'b1;
        @(negedge clk);
        if (pop_in_check) rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic gap();
        rflag = 1'b0;
        cyc(10);
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        logic [10:0] f;
        int next_frame;
        int hold;
        int r;

        // Flag held high across reset release must not create a frame.
        rst = 1'b1; rflag = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(3);
        chk("reset rd_valid", {31'd0, rd_valid}, 0);
        chk("reset rd_data", {24'd0, rd_data}, 0);
        chk("reset fifo_full", {31'd0, fifo_full}, 0);
        chk("reset drop_cnt", {24'd0, drop_cnt}, 0);
        chk("reset busy", {31'd0, busy}, 0);
        rflag = 1'b0;
        cyc(2);

        send(11'h54A, 1'b0);
        chk("good rd_valid", {31'd0, rd_valid}, 1);
        chk("good rd_data", {24'd0, rd_data}, 32'hA5);
        gap();
        pop1();
        chk("pop rd_valid", {31'd0, rd_valid}, 0);

        send(11'h54B, 1'b0);
        chk("start frame_err", {31'd0, frame_err}, 1);
        chk("start drop_cnt", {24'd0, drop_cnt}, 1);
        chk("start rd_valid", {31'd0, rd_valid}, 0);
        gap();
        clr();
        chk("clr frame_err", {31'd0, frame_err}, 0);
        chk("clr drop_cnt", {24'd0, drop_cnt}, 0);

        send(11'h74A, 1'b0);
`ifdef UART_RX_PARITY_EN
        chk("par parity_err", {31'd0, parity_err}, 1);
        chk("par drop_cnt", {24'd0, drop_cnt}, 1);
        chk("par rd_valid", {31'd0, rd_valid}, 0);
`else
        chk("nopar rd_data", {24'd0, rd_data}, 32'hA5);
        chk("nopar parity_err", {31'd0, parity_err}, 0);
`endif
        gap();
        clr();
        if (rd_valid) pop1();

        for (int i = 0; i < 5; i++) begin
            send(mk(8'h11 + 8'(i), 1'b1), 1'b0);
            if (i == 3) chk("ovr fifo_full", {31'd0, fifo_full}, 1);
            if (i == 4) begin
                chk("ovr overrun_err", {31'd0, overrun_err}, 1);
                chk("ovr drop_cnt", {24'd0, drop_cnt}, 1);
            end
            gap();
        end
        for (int i = 0; i < 4; i++) begin
            chk("ovr read", {24'd0, rd_data}, 32'h11 + i);
            pop1();
        end
        chk("ovr drained", {31'd0, rd_valid}, 0);
        clr();

        for (int i = 0; i < 4; i++) begin
            send(mk(8'h21 + 8'(i), 1'b1), 1'b0);
            gap();
        end
        send(mk(8'h25, 1'b1), 1'b1);
        chk("fullpop overrun_err", {31'd0, overrun_err}, 0);
        chk("fullpop fifo_full", {31'd0, fifo_full}, 1);
        chk("fullpop head", {24'd0, rd_data}, 32'h22);
        gap();
        for (int i = 0; i < 4; i++) begin
            chk("fullpop read", {24'd0, rd_data}, 32'h22 + i);
            pop1();
        end
        chk("fullpop drained", {31'd0, rd_valid}, 0);

        // Reset asserted while the frame is being checked.
        send(mk(8'h31, 1'b1), 1'b0);
        gap();
        pdata = mk(8'h32, 1'b1);
        rflag = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstchk rd_valid", {31'd0, rd_valid}, 0);
        chk("rstchk busy", {31'd0, busy}, 0);
        chk("rstchk drop_cnt", {24'd0, drop_cnt}, 0);
        rst = 1'b0;
        rflag = 1'b0;
        cyc(3);
        chk("rstchk no push", {31'd0, rd_valid}, 0);

        next_frame = 3;
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            rd_en   = ($urandom_range(0, 99) < (((c / 500) % 2 == 1) ? 30 : 2));
            err_clr = ($urandom_range(0, 199) == 0);
            active  = ($urandom_range(0, 3) == 0);
            if (hold > 0) begin
                hold--;
                if (hold == 0) rflag = 1'b0;
            end
            if (next_frame == 0) begin
                r = $urandom_range(0, 9);
                f = mk(8'($urandom), r != 3);
                if (r == 1) f[0] = 1'b1;
                if (r == 2) f[10] = 1'b0;
                pdata = f;
                rflag = 1'b1;
                hold = $urandom_range(1, 5);
                next_frame = $urandom_range(11, 20);
            end else begin
                next_frame--;
            end
            @(negedge clk);
        end

        rd_en = 1'b0; err_clr = 1'b0; active = 1'b0; rflag = 1'b0;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Receive-side frame controller between the SIPO UART receiver and the host. Captures each 11-bit frame the SIPO reports complete and checks its start, stop and parity bits. Good data bytes go into a small first-word-fall-through FIFO that the host drains with a valid/read handshake. Bad or overflowing frames are dropped, counted, and reported through sticky error flags.

## Interface
Parameters:
- FIFO_DEPTH, 4, byte FIFO depth; power of two, 2..16.
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd; used only with UART_RX_PARITY_EN.

Ports:
- baud_clk_rx  in  1  single clock; the same baud clock that drives the SIPO.
- rst  in  1  synchronous, active-high reset.
- parallel_data_rx  in  11  frame from the SIPO: [0] start, [8:1] data LSB-first, [9] parity, [10] stop.
- received_flag  in  1  SIPO frame-complete level; a 0->1 transition marks a new frame.
- active_flag_rx  in  1  SIPO mid-frame indicator; feeds busy only.
- rd_en  in  1  host pop request.
- err_clr  in  1  clears sticky flags and drop_cnt.
- rd_data  out  8  FIFO head byte; valid when rd_valid = 1.
- rd_valid  out  1  FIFO not empty.
- fifo_full  out  1  FIFO holds FIFO_DEPTH bytes.
- frame_err  out  1  sticky; start bit != 0 or stop bit != 1.
- parity_err  out  1  sticky; parity mismatch.
- overrun_err  out  1  sticky; good frame arrived while the FIFO was full.
- drop_cnt  out  8  count of discarded frames; saturates at 255.
- busy  out  1  active_flag_rx OR state != IDLE.

## Operation
- Edge detect: flag_d <= received_flag every cycle. A new frame is a cycle with received_flag = 1 and flag_d = 0.
- FSM states: IDLE and CHECK.
- IDLE: on a new frame, latch parallel_data_rx into frame_q and go to CHECK. All other cycles stay in IDLE.
- CHECK (exactly one cycle), then back to IDLE:
  - If frame_q[0] = 1 or frame_q[10] = 0: set frame_err, increment drop_cnt, no push.
  - Else, with the parity macro compiled in, if the parity check fails: set parity_err, increment drop_cnt, no push.
  - Else, if the FIFO is full and rd_en = 0: set overrun_err, increment drop_cnt, no push.
  - Otherwise push frame_q[8:1].
- Parity check: even mode requires the XOR of frame_q[9:1] to be 0; odd mode requires it to be 1.
- A new-frame edge that occurs while in CHECK is ignored and is not counted.
- FIFO is first-word-fall-through. rd_en with rd_valid = 1 pops at the clock edge; rd_en with an empty FIFO is ignored.
- Push and pop in the same cycle both take effect, including when the FIFO is full. Occupancy is unchanged.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Occupancy uses log2(FIFO_DEPTH)+1 bits.
- err_clr clears frame_err, parity_err, overrun_err and drop_cnt. If an error is detected in the same cycle, the set/increment wins: flag = 1, drop_cnt = 1.
- drop_cnt holds at 255 once it saturates.

## Timing
- Reset values:
  - All outputs are 0: rd_data = 0x00, rd_valid = 0, fifo_full = 0, all error flags = 0, drop_cnt = 0, busy = 0 (busy still follows active_flag_rx).
  - FIFO is empty, FSM is in IDLE.
  - flag_d resets to 1, so a received_flag already high at reset release does not create a frame.
- Latency, with edge E0 being the first edge that samples received_flag = 1:
  - E0: frame_q is loaded and the FSM enters CHECK.
  - E1: the push or error update is registered.
  - rd_valid and the error flags become visible after E1.
- Pop: rd_data moves to the next entry, or rd_valid drops, after the edge that samples rd_en = 1.
- fifo_full and rd_valid are registered and change only on clock edges.
- Reset mid-operation (rst high while in CHECK): the frame is discarded, nothing is pushed, and the block returns to its reset state on that edge.
- The minimum frame spacing from the SIPO is 11 baud clocks, so CHECK never collides with a legal frame.

## Configuration
- UART_RX_PARITY_EN defined: the parity bit is checked against PARITY_ODD; failing frames set parity_err and are dropped.
- UART_RX_PARITY_EN undefined: frame_q[9] is ignored, parity_err is tied to 0, and the parity logic is removed.

## Test plan
- Frame 0x54A (start 0, data 0xA5, parity 0, stop 1), even parity: rd_valid = 1 two edges after the flag is sampled and rd_data = 0xA5. Pulse rd_en once: rd_valid = 0.
- Frame 0x54B (start bit 1): frame_err = 1, drop_cnt = 1, rd_valid stays 0. Pulse err_clr: frame_err = 0, drop_cnt = 0.
- Frame 0x74A (parity bit 1, even mode):
  - Macro defined: parity_err = 1, drop_cnt = 1, nothing pushed.
  - Macro undefined: rd_data = 0xA5, parity_err = 0.
- Overrun, FIFO_DEPTH = 4: five good frames 0x11..0x15 with no reads. fifo_full = 1 after the fourth frame; the fifth sets overrun_err = 1 and drop_cnt = 1. Four reads return 0x11, 0x12, 0x13, 0x14, then rd_valid = 0.
- Full with a simultaneous pop: FIFO holds four bytes and rd_en = 1 in the frame's CHECK cycle. The byte is pushed, overrun_err stays 0, and fifo_full stays 1.
- Reset cases:
  - Assert rst in CHECK: no push, all outputs 0.
  - Hold received_flag = 1 across reset release: no frame captured.
